// File: rtl/merge_arb_pkg.sv
// Shared interconnect definitions for the native-bus merge arbiter: packed widths, field offsets
// and FSM state encodings.
package merge_arb_pkg;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  // Request {valid, addr, wdata, wstrb} and response {rdata, ready}, MSB first.
  localparam int unsigned ReqWstrbLsb  = 0;
  localparam int unsigned RespReadyBit = 0;
  localparam int unsigned RespRdataLsb = 1;

  function automatic int unsigned req_w(input int unsigned addr_w, input int unsigned data_w);
    return 1 + addr_w + data_w + data_w / 8;
  endfunction

  function automatic int unsigned resp_w(input int unsigned data_w);
    return data_w + 1;
  endfunction

  function automatic int unsigned req_wdata_lsb(input int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic int unsigned req_addr_lsb(input int unsigned data_w);
    return data_w + data_w / 8;
  endfunction

  function automatic int unsigned req_valid_bit(input int unsigned addr_w,
                                                input int unsigned data_w);
    return addr_w + data_w + data_w / 8;
  endfunction

endpackage

// File: rtl/arb_rr.sv
// Combinational rotating-priority arbiter: searches upward from ptr_i with wrap and returns the
// first requester as a one-hot grant and an index.
module arb_rr #(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o
);

  int unsigned     cand;
  logic [IdxW-1:0] cand_idx;
  logic            found;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = 32'(ptr_i) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      cand_idx = IdxW'(cand);
      if (!found && req_i[cand_idx]) begin
        found           = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/merge_arb.sv
// Merges N native-bus masters onto one slave port with round-robin or fixed-priority arbitration
// and a deferred, idle-only invalidate pulse toward the slave.
module merge_arb
  import merge_arb_pkg::*;
#(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned RR        = 1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [N_MASTERS*req_w(ADDR_W, DATA_W)-1:0] m_req,
  output logic [N_MASTERS*resp_w(DATA_W)-1:0]        m_resp,
  output logic [req_w(ADDR_W, DATA_W)-1:0]           s_req,
  input  logic [resp_w(DATA_W)-1:0]                  s_resp,
  input  logic                                        inv_in,
  output logic                                        inv_out
);

  localparam int unsigned ReqW     = req_w(ADDR_W, DATA_W);
  localparam int unsigned RespW    = resp_w(DATA_W);
  localparam int unsigned ValidBit = req_valid_bit(ADDR_W, DATA_W);
  localparam int unsigned IdxW     = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  logic [0:0]           state_q, state_d;
  logic                 inv_pend_q, inv_pend_d;
  logic                 busy, done, launch, any_valid;
  logic [N_MASTERS-1:0] m_valid;
  logic [IdxW-1:0]      grant;

  always_comb begin
    m_valid = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      m_valid[i] = m_req[i*ReqW + ValidBit];
    end
  end

  assign busy    = (state_q == StBusy);
  assign done    = busy && s_resp[RespReadyBit];
  assign inv_out = !busy && inv_pend_q;
  // A pending invalidate blocks new grants for the cycle it is issued.
  assign launch  = !busy && !inv_pend_q && any_valid;

  always_comb begin
    state_d = state_q;
    if (launch) begin
      state_d = StBusy;
    end else if (done) begin
      state_d = StIdle;
    end
    inv_pend_d = inv_in || (inv_pend_q && !inv_out);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      inv_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inv_pend_q <= inv_pend_d;
    end
  end

  if (N_MASTERS > 1) begin : g_arb
    logic [IdxW-1:0]      ptr, win_idx, grant_q, grant_d;
    logic [N_MASTERS-1:0] win_oh;

    arb_rr #(
      .N    (N_MASTERS),
      .IdxW (IdxW)
    ) u_arb (
      .req_i (m_valid),
      .ptr_i (ptr),
      .gnt_o (win_oh),
      .idx_o (win_idx)
    );

    assign any_valid = |win_oh;
    assign grant     = grant_q;

    always_comb begin
      grant_d = launch ? win_idx : grant_q;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        grant_q <= '0;
      end else begin
        grant_q <= grant_d;
      end
    end

    if (RR != 0) begin : g_rr
      logic [IdxW-1:0] ptr_q, ptr_d;

      always_comb begin
        ptr_d = ptr_q;
        if (done) begin
          ptr_d = (grant_q == IdxW'(N_MASTERS - 1)) ? '0 : grant_q + 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          ptr_q <= '0;
        end else begin
          ptr_q <= ptr_d;
        end
      end

      assign ptr = ptr_q;
    end else begin : g_fixed
      assign ptr = '0;
    end
  end else begin : g_single
    assign any_valid = m_valid[0];
    assign grant     = '0;
  end

  always_comb begin
    s_req  = '0;
    m_resp = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      m_resp[i*RespW + RespRdataLsb +: DATA_W] = s_resp[RespRdataLsb +: DATA_W];
      if (busy && (grant == IdxW'(i))) begin
        s_req                           = m_req[i*ReqW +: ReqW];
        m_resp[i*RespW + RespReadyBit] = s_resp[RespReadyBit];
      end
    end
  end

endmodule

// File: doc/merge_arb.md
MERGE_ARB -- requirements
Module: merge_arb

Interface
REQ-001 Parameter N_MASTERS, default 2: number of native-bus masters merged, range 1..8.
REQ-002 Parameter ADDR_W, default 32: word-address width of every request.
REQ-003 Parameter DATA_W, default 32: data width; WSTRB width is DATA_W/8.
REQ-004 Parameter RR, default 1: arbitration mode.
  - 1: round-robin.
  - 0: fixed priority, lowest index wins.
REQ-005 Derived constants: REQ_W = 1+ADDR_W+DATA_W+DATA_W/8; RESP_W = DATA_W+1.
REQ-006 Request field order, MSB first: {valid, addr, wdata, wstrb}. Response field order, MSB first: {rdata, ready}.
REQ-007 clk  input  1  single system clock; all state updates on its rising edge.
REQ-008 rst  input  1  reset, asynchronous and active-low.
REQ-009 m_req  input  N_MASTERS*REQ_W  master requests; master 0 occupies the LSBs.
REQ-010 m_resp  output  N_MASTERS*RESP_W  master responses; same packing as m_req.
REQ-011 s_req  output  REQ_W  merged request to the slave.
REQ-012 s_resp  input  RESP_W  slave response.
REQ-013 inv_in  input  1  one-cycle invalidate request from the control path.
REQ-014 inv_out  output  1  one-cycle invalidate pulse to the slave, issued only while the slave is idle.

Function
REQ-015 The FSM SHALL have two states, IDLE and BUSY.
REQ-016 In IDLE, with no invalidate pending and at least one master valid, the FSM SHALL register the winner in grant, then go to BUSY.
REQ-017 In BUSY, s_req SHALL equal m_req[grant] combinationally; in IDLE, s_req SHALL be all zero.
REQ-018 In BUSY, m_resp[grant].ready SHALL equal s_resp.ready; every other master's ready SHALL be 0.
REQ-019 rdata SHALL be s_resp.rdata broadcast to all masters.
REQ-020 On s_resp.ready in BUSY, the FSM SHALL return to IDLE on the next edge.
  - Minimum occupancy is 2 cycles per transaction: IDLE grant, BUSY accept.
REQ-021 RR=1: after each completion the priority pointer SHALL be set to grant+1, wrapping from N_MASTERS-1 to 0.
  - The arbiter SHALL search upward from the pointer, with wrap.
REQ-022 RR=0: the pointer SHALL stay at 0.
REQ-023 Masters hold valid and request fields stable until their ready. A master dropping valid while BUSY SHALL NOT abort the transaction; the FSM still waits for s_resp.ready.
REQ-024 inv_in SHALL set inv_pend; inv_pend SHALL stay set until serviced.
REQ-025 In IDLE with inv_pend=1:
  - inv_out SHALL pulse for exactly one cycle and inv_pend SHALL clear.
  - No grant SHALL be issued in that cycle; invalidate has priority over new grants.
REQ-026 inv_in arriving while BUSY SHALL be deferred until the next IDLE cycle.
REQ-027 inv_in arriving in the same cycle as an inv_out pulse SHALL re-set inv_pend, producing a second pulse.
REQ-028 N_MASTERS=1 SHALL synthesize with grant fixed at 0 and no pointer logic.

Reset
REQ-029 While rst=0, the block SHALL hold: state=IDLE, grant=0, pointer=0, inv_pend=0, inv_out=0, s_req=0, all ready=0.
REQ-030 Reset asserted mid-transaction SHALL abandon it immediately; there is no response to the master.
REQ-031 The first grant SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-032 REQ_W, RESP_W and the field-offset macros (valid, address, wdata, wstrb, rdata, ready) SHALL come from the shared interconnect header, not be redefined locally.
REQ-033 One sub-module, arb_rr: N-bit request vector plus pointer in, one-hot grant and grant index out, purely combinational; merge_arb instantiates it once.
REQ-034 Total RTL SHALL be 120-400 lines.

Verification
REQ-035 Single master: N=2, master 1 reads addr 0x40; slave returns ready with rdata 0xDEADBEEF after 3 cycles.
  - Required: s_req mirrors master 1 one cycle after valid; m_resp[1] = {0xDEADBEEF, 1}; m_resp[0].ready = 0.
REQ-036 Round-robin fairness: N=3, RR=1, all masters continuously valid, slave ready=1 every BUSY cycle.
  - Required: grant order 0,1,2,0,1,2; one completion every 2 cycles.
REQ-037 Fixed priority: RR=0, masters 0 and 2 continuously valid.
  - Required: master 0 always wins; master 2 starves.
REQ-038 Deferred invalidate: inv_in pulses while BUSY and slave ready is delayed 5 cycles.
  - Required: inv_out stays 0 until the cycle after completion, then pulses once; the pending grant is delayed by one cycle.
REQ-039 Reset mid-transaction: rst=0 while BUSY, masters still valid.
  - Required: outputs zero asynchronously; after release, the grant restarts from master 0.
